// File: rtl/voice_mixer.sv
// Voice mixer: sums one signed sample per voice over a full frame, attenuates
// and saturates the sum, and offers one mixed sample per frame over valid/ready.
// Also flags clipping, dropped frames (overrun) and out-of-order voice indices.
module voice_mixer #(
  parameter int unsigned NUM_VOICES = 64,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned SHIFT      = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [7:0]          i_voice_index,
  input  logic [1:0]          i_pipeline_state,
  input  logic                i_voice_active,
  output logic [SAMPLE_W-1:0] o_mix,
  output logic                o_mix_valid,
  input  logic                i_mix_ready,
  output logic                o_clip,
  output logic                o_overrun,
  output logic                o_seq_error
);

  typedef enum logic [0:0] {StSync, StAccum} state_e;

  localparam logic [7:0]              LastIdx = 8'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SatMax  = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SatMin  = ~SatMax;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               exp_q, exp_d;
  logic [SAMPLE_W-1:0]      mix_q, mix_d;
  logic                     valid_q, valid_d;
  logic                     clip_q, clip_d;
  logic                     overrun_q, overrun_d;
  logic                     seq_q;

  logic                     strobe;
  logic                     idx_range_err;
  logic signed [ACC_W-1:0]  contrib;
  logic signed [ACC_W-1:0]  frame_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [SAMPLE_W-1:0]      sat_mix;
  logic                     sat_hit;
  logic                     frame_done;
  logic                     seq_err;
  logic                     load;

  // Strobe decode, gated contribution and the saturated frame result.
  always_comb begin
    strobe        = (i_pipeline_state == 2'd2);
    idx_range_err = ({1'b0, i_voice_index} >= 9'(NUM_VOICES));
    contrib       = i_voice_active ? ACC_W'($signed(i_sample)) : '0;
    frame_sum     = acc_q + contrib;
    shifted       = frame_sum >>> SHIFT;
    sat_hit       = 1'b0;
    if (shifted > SatMax) begin
      sat_mix = {1'b0, {(SAMPLE_W - 1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < SatMin) begin
      sat_mix = {1'b1, {(SAMPLE_W - 1){1'b0}}};
      sat_hit = 1'b1;
    end else begin
      sat_mix = shifted[SAMPLE_W-1:0];
    end
  end

  // Frame sequencing FSM: lock on voice 0, accumulate in order, resync on error.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    exp_d      = exp_q;
    frame_done = 1'b0;
    seq_err    = 1'b0;
    if (strobe) begin
      case (state_q)
        StSync: begin
          if (idx_range_err) begin
            seq_err = 1'b1;
          end else if (i_voice_index == 8'd0) begin
            acc_d   = contrib;
            exp_d   = 8'd1;
            state_d = StAccum;
          end
        end
        StAccum: begin
          if (i_voice_index == exp_q) begin
            if (i_voice_index == LastIdx) begin
              frame_done = 1'b1;
              acc_d      = '0;
              exp_d      = 8'd0;
            end else begin
              acc_d = frame_sum;
              exp_d = exp_q + 8'd1;
            end
          end else begin
            seq_err = 1'b1;
            // A stray voice 0 is itself a valid frame start: re-enter at once.
            if (i_voice_index == 8'd0) begin
              acc_d = contrib;
              exp_d = 8'd1;
            end else begin
              acc_d   = '0;
              exp_d   = 8'd0;
              state_d = StSync;
            end
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  // Output holding register: load on frame completion unless a frame is still
  // pending and not being taken this cycle, in which case the new one is dropped.
  always_comb begin
    load      = frame_done & (~valid_q | i_mix_ready);
    mix_d     = mix_q;
    valid_d   = valid_q;
    clip_d    = 1'b0;
    overrun_d = overrun_q;
    if (load) begin
      mix_d   = sat_mix;
      valid_d = 1'b1;
      clip_d  = sat_hit;
    end else if (valid_q & i_mix_ready) begin
      valid_d = 1'b0;
    end
    if (frame_done & valid_q & ~i_mix_ready) begin
      overrun_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StSync;
      acc_q     <= '0;
      exp_q     <= 8'd0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      exp_q     <= exp_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
      seq_q     <= seq_err;
    end
  end

  assign o_mix       = mix_q;
  assign o_mix_valid = valid_q;
  assign o_clip      = clip_q;
  assign o_overrun   = overrun_q;
  assign o_seq_error = seq_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed test-plan steps plus random frames, checked
// against a sum/shift/saturate model. Two instances share stimulus (SHIFT 0 and 2).
module tb_voice_mixer;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample;
  logic [7:0]  vidx;
  logic [1:0]  pstate;
  logic        vact;
  logic        ready;

  logic [15:0] mix0, mix2;
  logic        valid0, valid2, clip0, clip2, ov0, ov2, seq0, seq2;

  int checks = 0;
  int errors = 0;
  int fs[NV];
  bit fa[NV];

  voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(16), .ACC_W(24), .SHIFT(0)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_sample(sample), .i_voice_index(vidx),
    .i_pipeline_state(pstate), .i_voice_active(vact), .o_mix(mix0),
    .o_mix_valid(valid0), .i_mix_ready(ready), .o_clip(clip0), .o_overrun(ov0),
    .o_seq_error(seq0)
  );

  voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(16), .ACC_W(24), .SHIFT(2)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_sample(sample), .i_voice_index(vidx),
    .i_pipeline_state(pstate), .i_voice_active(vact), .o_mix(mix2),
    .o_mix_valid(valid2), .i_mix_ready(ready), .o_clip(clip2), .o_overrun(ov2),
    .o_seq_error(seq2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] sx(input logic [15:0] v);
    return 32'(signed'(v));
  endfunction

  function automatic logic signed [31:0] zx(input logic b);
    return 32'(b);
  endfunction

  // Reference: sum the active contributions, arithmetic shift, clamp to 16 bits.
  function automatic int model_mix(input int shift, output bit clip);
    int sum;
    sum = 0;
    for (int v = 0; v < NV; v++) if (fa[v]) sum += fs[v];
    sum = sum >>> shift;
    clip = 1'b0;
    if (sum > 32767) begin
      sum  = 32767;
      clip = 1'b1;
    end else if (sum < -32768) begin
      sum  = -32768;
      clip = 1'b1;
    end
    return sum;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One voice slot: phases 0 and 1 carry junk, phase 2 carries the real data.
  // Returns 1 time unit after the strobe edge.
  task automatic send(input int idx, input int smp, input bit act, input bit raise_rdy);
    pstate = 2'd0; vidx = 8'($urandom); sample = 16'($urandom); vact = 1'($urandom);
    tick();
    pstate = 2'd1; vidx = 8'($urandom); sample = 16'($urandom); vact = 1'($urandom);
    tick();
    pstate = 2'd2; vidx = 8'(idx); sample = 16'(smp); vact = act;
    if (raise_rdy) ready = 1'b1;
    tick();
    pstate = 2'd0;
  endtask

  task automatic send_frame();
    for (int v = 0; v < NV; v++) send(v, fs[v], fa[v], 1'b0);
  endtask

  task automatic fill(input int a, input int b, input int c, input int d);
    fs[0] = a; fs[1] = b; fs[2] = c; fs[3] = d;
    for (int v = 0; v < NV; v++) fa[v] = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    int e0, e2;
    bit c0, c2;
    e0 = model_mix(0, c0);
    e2 = model_mix(2, c2);
    chk({tag, "_valid"}, zx(valid0), 32'sd1);
    chk({tag, "_mix"}, sx(mix0), e0);
    chk({tag, "_clip"}, zx(clip0), zx(c0));
    chk({tag, "_mix_s2"}, sx(mix2), e2);
    chk({tag, "_clip_s2"}, zx(clip2), zx(c2));
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] r;
    rst_n = 1'b1; pstate = 2'd0; sample = '0; vidx = '0; vact = 1'b0; ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mix", sx(mix0), 32'sd0);
    chk("rst_valid", zx(valid0), 32'sd0);
    chk("rst_clip", zx(clip0), 32'sd0);
    chk("rst_overrun", zx(ov0), 32'sd0);
    chk("rst_seq", zx(seq0), 32'sd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic sum
    ready = 1'b1;
    fill(100, 200, -50, 25);
    for (int v = 0; v < 3; v++) send(v, fs[v], fa[v], 1'b0);
    chk("basic_pre_valid", zx(valid0), 32'sd0);
    send(3, fs[3], fa[3], 1'b0);
    check_frame("basic");
    chk("basic_275", sx(mix0), 32'sd275);
    tick();
    chk("basic_valid_drop", zx(valid0), 32'sd0);

    // Mid-frame start after reset, then a gated frame
    pulse_reset();
    send(2, 777, 1'b1, 1'b0);
    send(3, 888, 1'b1, 1'b0);
    chk("sync_ignore_valid", zx(valid0), 32'sd0);
    chk("sync_ignore_seq", zx(seq0), 32'sd0);
    fill(10, 20, 30, 40);
    fa[1] = 1'b0;
    send_frame();
    check_frame("gate");
    chk("gate_80", sx(mix0), 32'sd80);

    // Saturation
    fill(16000, 16000, 16000, 16000);
    send_frame();
    check_frame("sat_pos");
    chk("sat_pos_32767", sx(mix0), 32'sd32767);
    chk("sat_pos_s2_16000", sx(mix2), 32'sd16000);
    tick();
    chk("clip_one_cycle", zx(clip0), 32'sd0);
    fill(-16000, -16000, -16000, -16000);
    send_frame();
    check_frame("sat_neg");
    chk("sat_neg_min", sx(mix0), -32'sd32768);
    tick();

    // Backpressure: hold, drop, then transfer coincident with a new load
    ready = 1'b0;
    fill(1, 1, 1, 1);
    send_frame();
    chk("bp1_mix", sx(mix0), 32'sd4);
    chk("bp1_valid", zx(valid0), 32'sd1);
    chk("bp1_overrun", zx(ov0), 32'sd0);
    chk("bp1_mix_s2", sx(mix2), 32'sd1);
    fill(2, 2, 2, 2);
    send_frame();
    chk("bp2_mix_held", sx(mix0), 32'sd4);
    chk("bp2_valid", zx(valid0), 32'sd1);
    chk("bp2_overrun", zx(ov0), 32'sd1);
    chk("bp2_mix_s2_held", sx(mix2), 32'sd1);
    for (int v = 0; v < 3; v++) send(v, 3, 1'b1, 1'b0);
    chk("bp3_pre_mix", sx(mix0), 32'sd4);
    send(3, 3, 1'b1, 1'b1);
    chk("bp3_mix", sx(mix0), 32'sd12);
    chk("bp3_valid", zx(valid0), 32'sd1);
    chk("bp3_mix_s2", sx(mix2), 32'sd3);
    chk("bp3_overrun_sticky", zx(ov0), 32'sd1);
    tick();
    chk("bp3_valid_drop", zx(valid0), 32'sd0);

    // Sequence error, then clean frame
    send(0, 1, 1'b1, 1'b0);
    send(1, 1, 1'b1, 1'b0);
    chk("seq_none_yet", zx(seq0), 32'sd0);
    send(3, 1, 1'b1, 1'b0);
    chk("seq_pulse", zx(seq0), 32'sd1);
    chk("seq_no_valid", zx(valid0), 32'sd0);
    tick();
    chk("seq_one_cycle", zx(seq0), 32'sd0);
    fill(1, 1, 1, 1);
    send_frame();
    check_frame("seq_clean");
    chk("seq_clean_4", sx(mix0), 32'sd4);

    // Stray voice 0 restarts the frame in the same cycle
    send(0, 9, 1'b1, 1'b0);
    send(1, 9, 1'b1, 1'b0);
    fill(5, 6, 7, 8);
    send(0, fs[0], 1'b1, 1'b0);
    chk("resync_seq", zx(seq0), 32'sd1);
    for (int v = 1; v < NV; v++) send(v, fs[v], fa[v], 1'b0);
    check_frame("resync");
    chk("resync_26", sx(mix0), 32'sd26);

    // Out-of-range index
    send(0, 1, 1'b1, 1'b0);
    send(9, 1, 1'b1, 1'b0);
    chk("range_seq", zx(seq0), 32'sd1);
    fill(2, 2, 2, 2);
    send_frame();
    check_frame("range_clean");

    // Asynchronous reset mid-frame with a pending output
    tick();
    ready = 1'b0;
    fill(1, 1, 1, 1);
    send_frame();
    chk("ar_pre_valid", zx(valid0), 32'sd1);
    send(0, 50, 1'b1, 1'b0);
    send(1, 50, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mix", sx(mix0), 32'sd0);
    chk("ar_valid", zx(valid0), 32'sd0);
    chk("ar_overrun", zx(ov0), 32'sd0);
    chk("ar_clip", zx(clip0), 32'sd0);
    chk("ar_seq", zx(seq0), 32'sd0);
    chk("ar_valid_s2", zx(valid2), 32'sd0);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    send(2, 50, 1'b1, 1'b0);
    send(3, 50, 1'b1, 1'b0);
    chk("ar_partial_no_valid", zx(valid0), 32'sd0);
    fill(7, -3, 11, 2);
    send_frame();
    check_frame("ar_full");
    chk("ar_full_17", sx(mix0), 32'sd17);

    // Random frames
    for (int i = 0; i < 24; i++) begin
      for (int v = 0; v < NV; v++) begin
        r = 16'($urandom);
        fs[v] = (i % 2 == 1) ? int'($signed(r)) : (int'($signed(r)) >>> 4);
        fa[v] = 1'($urandom_range(0, 1));
      end
      send_frame();
      check_frame($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Sits directly downstream of the wavetable stage. Consumes one signed 16-bit sample per voice per pipeline round.
- Sums the samples over a full voice frame (voice 0 .. NUM_VOICES-1), attenuates the sum and saturates it to 16 bits.
- Presents one mixed sample per frame to the DAC/output stage through a valid/ready handshake.
- Also tracks the voice sequence and flags clipping, overrun and sequence errors.

Parameters:
- NUM_VOICES, 64: voices per frame; voice indices 0..NUM_VOICES-1; legal range 2..256.
- SAMPLE_W, 16: width of the input sample and of the output sample.
- ACC_W, 24: accumulator width; must satisfy ACC_W >= SAMPLE_W + clog2(NUM_VOICES).
- SHIFT, 4: arithmetic right shift applied to the frame sum before saturation.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_sample  in  SAMPLE_W signed  wavetable output sample.
- i_voice_index  in  8  voice index, aligned with i_sample (wavetable o_voice_index_next).
- i_pipeline_state  in  2  shared voice pipeline phase counter (0,1,2).
- i_voice_active  in  1  voice gate; 0 means the voice contributes 0 but still counts in the sequence.
- o_mix  out  SAMPLE_W signed  mixed frame sample.
- o_mix_valid  out  1  o_mix holds an unconsumed frame.
- i_mix_ready  in  1  downstream accepts o_mix when o_mix_valid & i_mix_ready.
- o_clip  out  1  one-cycle pulse when the loaded frame was saturated.
- o_overrun  out  1  sticky; a frame was dropped because o_mix was not consumed.
- o_seq_error  out  1  one-cycle pulse on an out-of-order voice index.

Behaviour:
- Reset (i_reset=0, async):
  - o_mix=0, o_mix_valid=0, o_clip=0, o_overrun=0, o_seq_error=0.
  - Accumulator=0, expected index=0, FSM=SYNC.
- Sample strobe: i_pipeline_state==2. i_sample/i_voice_index are stable then, since the wavetable registers its output in state 1. No other state is sampled. State 3 is ignored.
- Contribution on a strobe: i_voice_active ? sign-extended i_sample : 0.
- FSM SYNC:
  - Strobes are ignored until one arrives with i_voice_index==0.
  - On that strobe: acc<=contribution, expected<=1, go to ACCUM.
- FSM ACCUM, strobe with index==expected:
  - acc<=acc+contribution, expected<=expected+1.
  - If index==NUM_VOICES-1: frame complete; acc<=0, expected<=0, stay in ACCUM.
  - The next frame's voice 0 then performs acc<=contribution, so there is no stale carry-over.
- FSM ACCUM, strobe with index!=expected:
  - Pulse o_seq_error, discard the partial sum, go to SYNC.
  - If that same index is 0, treat it as a SYNC-entry strobe in the same cycle; no frame is lost beyond the partial one.
- Frame result: sum = (acc + last contribution) >>> SHIFT (arithmetic).
  - Saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - o_clip pulses in the cycle o_mix is loaded, if saturation occurred.
- Output latency: o_mix/o_mix_valid update on the clock edge that samples the final voice's strobe, i.e. visible the cycle after the final strobe.
- Handshake:
  - Transfer = o_mix_valid & i_mix_ready. After a transfer, o_mix_valid drops the next cycle unless a new frame loads on the same edge.
  - o_mix is held constant while o_mix_valid=1 and not transferred.
- Frame completes while o_mix_valid=1 and i_mix_ready=0: the new frame is dropped, o_mix keeps the old value, o_overrun<=1 (sticky until reset).
- Frame completes on the same edge as a transfer: the new frame loads, o_mix_valid stays 1, no overrun.
- i_voice_index >= NUM_VOICES: always a sequence error.
- Reset mid-frame: partial sum is lost. After release, the block resyncs on the next voice 0 and the first output follows the first complete frame.

Test Plan (NUM_VOICES=4, SHIFT=0 unless noted; strobes every 3 cycles):
- Basic sum: reset, then voices 0..3 with samples 100,200,-50,25, all active, ready=1 -> o_mix=275, o_mix_valid high one cycle after voice 3, o_clip=0.
- Gating and mid-frame start: start the stream at voice 2, then a full frame 10,20,30,40 with voice 1 inactive -> first frame ignored (SYNC), o_mix=80.
- Saturation: all four samples 16000 -> o_mix=32767 with an o_clip pulse; all four -16000 -> o_mix=-32768 with an o_clip pulse. With SHIFT=2: 4x16000 -> o_mix=16000, no clip.
- Backpressure: ready=0 across two frames (sums 4 then 8) -> o_mix stays 4, o_overrun=1. Raise ready on the edge where the third frame (sum 12) completes -> o_mix=12, valid stays high, no further overrun.
- Sequence error: voices 0,1,3 -> o_seq_error pulse at voice 3, no output. Then a clean frame 1,1,1,1 -> o_mix=4.
- Async reset: assert i_reset=0 between clock edges mid-frame with o_mix_valid=1 -> all outputs 0 immediately. After release, a full frame is required before valid.
